// File: rtl/axi_lite_slave_regs_if.sv
// AXI4-Lite bus bundle between a register-bank responder (slave) and its driver (master).
// Clock and reset are not part of this interface; they stay plain ports on the modules.
interface axi_lite_slave_regs_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   AWADDR;
  logic                    AWVALID;
  logic                    AWREADY;
  logic [DATA_WIDTH-1:0]   WDATA;
  logic [DATA_WIDTH/8-1:0] WSTRB;
  logic                    WVALID;
  logic                    WREADY;
  logic                    BVALID;
  logic                    BREADY;
  logic [ADDR_WIDTH-1:0]   ARADDR;
  logic                    ARVALID;
  logic                    ARREADY;
  logic [DATA_WIDTH-1:0]   RDATA;
  logic                    RVALID;
  logic                    RREADY;

  modport slave (
    input  AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
    output AWREADY, WREADY, BVALID, ARREADY, RDATA, RVALID
  );

  modport master (
    output AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
    input  AWREADY, WREADY, BVALID, ARREADY, RDATA, RVALID
  );
endinterface

// File: rtl/axi_lite_slave_regs.sv
// AXI4-Lite register bank: NUM_REGS word-addressed registers with byte strobes,
// independent write and read channel FSMs, every access answered OKAY.
module axi_lite_slave_regs #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 2**(ADDR_WIDTH-2)
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  axi_lite_slave_regs_if.slave  bus
);

  localparam int STRB_W = DATA_WIDTH/8;
  localparam int IDX_W  = ADDR_WIDTH-2;

  typedef enum logic [1:0] {WR_IDLE, WR_NEED_W, WR_NEED_AW, WR_RESP} wr_state_t;
  typedef enum logic {RD_IDLE, RD_DATA} rd_state_t;

  wr_state_t             wr_state;
  rd_state_t             rd_state;
  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic [IDX_W-1:0]      aw_idx_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_W-1:0]     wstrb_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic                  commit_en;
  logic [IDX_W-1:0]      commit_idx;
  logic [DATA_WIDTH-1:0] commit_data;
  logic [STRB_W-1:0]     commit_strb;

  // Byte lanes of the address are ignored: the bank is word-addressed.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = &{1'b0, bus.AWADDR[1:0], bus.ARADDR[1:0]};

  function automatic logic [DATA_WIDTH-1:0] apply_wstrb(
    input logic [DATA_WIDTH-1:0] cur,
    input logic [DATA_WIDTH-1:0] wdata,
    input logic [STRB_W-1:0]     strb
  );
    logic [DATA_WIDTH-1:0] res;
    res = cur;
    for (int i = 0; i < STRB_W; i++) begin
      if (strb[i]) res[i*8 +: 8] = wdata[i*8 +: 8];
    end
    return res;
  endfunction

  // Handshake readiness is a pure state decode; reset forces the READYs low.
  assign bus.AWREADY = ARESETn && (wr_state == WR_IDLE || wr_state == WR_NEED_AW);
  assign bus.WREADY  = ARESETn && (wr_state == WR_IDLE || wr_state == WR_NEED_W);
  assign bus.BVALID  = (wr_state == WR_RESP);
  assign bus.ARREADY = ARESETn && (rd_state == RD_IDLE);
  assign bus.RVALID  = (rd_state == RD_DATA);
  assign bus.RDATA   = rdata_q;

  // The final write handshake picks whichever half (address or data) arrives live.
  always_comb begin
    commit_en   = 1'b0;
    commit_idx  = aw_idx_q;
    commit_data = wdata_q;
    commit_strb = wstrb_q;
    case (wr_state)
      WR_IDLE: begin
        if (bus.AWVALID && bus.WVALID) begin
          commit_en   = 1'b1;
          commit_idx  = bus.AWADDR[ADDR_WIDTH-1:2];
          commit_data = bus.WDATA;
          commit_strb = bus.WSTRB;
        end
      end
      WR_NEED_W: begin
        if (bus.WVALID) begin
          commit_en   = 1'b1;
          commit_data = bus.WDATA;
          commit_strb = bus.WSTRB;
        end
      end
      WR_NEED_AW: begin
        if (bus.AWVALID) begin
          commit_en  = 1'b1;
          commit_idx = bus.AWADDR[ADDR_WIDTH-1:2];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      wr_state <= WR_IDLE;
      aw_idx_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
    end else begin
      case (wr_state)
        WR_IDLE: begin
          if (bus.AWVALID && bus.WVALID) begin
            wr_state <= WR_RESP;
          end else if (bus.AWVALID) begin
            aw_idx_q <= bus.AWADDR[ADDR_WIDTH-1:2];
            wr_state <= WR_NEED_W;
          end else if (bus.WVALID) begin
            wdata_q  <= bus.WDATA;
            wstrb_q  <= bus.WSTRB;
            wr_state <= WR_NEED_AW;
          end
        end
        WR_NEED_W:  if (bus.WVALID)  wr_state <= WR_RESP;
        WR_NEED_AW: if (bus.AWVALID) wr_state <= WR_RESP;
        WR_RESP:    if (bus.BREADY)  wr_state <= WR_IDLE;
        default:    wr_state <= WR_IDLE;
      endcase
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (commit_en) begin
      regs[commit_idx] <= apply_wstrb(regs[commit_idx], commit_data, commit_strb);
    end
  end

  // A read sampling the same register a write commits on this edge sees the old value.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      rd_state <= RD_IDLE;
      rdata_q  <= '0;
    end else begin
      case (rd_state)
        RD_IDLE: begin
          if (bus.ARVALID) begin
            rdata_q  <= regs[bus.ARADDR[ADDR_WIDTH-1:2]];
            rd_state <= RD_DATA;
          end
        end
        RD_DATA: if (bus.RREADY) rd_state <= RD_IDLE;
        default: rd_state <= RD_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_slave_regs.sv
// Bench for axi_lite_slave_regs: directed scenarios followed by random reads/writes
// with random handshake delays, checked against a word-array model of the bank.
module tb_axi_lite_slave_regs;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;
  logic [31:0] mem [4];

  always #5 clk = ~clk;

  axi_lite_slave_regs_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) bus ();

  axi_lite_slave_regs #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) dut (
    .ACLK    (clk),
    .ARESETn (rst_n),
    .bus     (bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] strobe_merge(input logic [31:0] old, input logic [31:0] d,
                                               input logic [3:0] s);
    logic [31:0] m;
    m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    return (old & ~m) | (d & m);
  endfunction

  task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int aw_dly, input int w_dly, input int b_dly);
    bit aw_done, w_done, hs_aw, hs_w;
    int cyc;
    aw_done = 0; w_done = 0; cyc = 0;
    bus.BREADY = (b_dly == 0);
    bus.AWADDR = a; bus.WDATA = d; bus.WSTRB = s;
    while (!(aw_done && w_done) && cyc < 64) begin
      bus.AWVALID = !aw_done && (cyc >= aw_dly);
      bus.WVALID  = !w_done && (cyc >= w_dly);
      hs_aw = bus.AWVALID && bus.AWREADY;
      hs_w  = bus.WVALID && bus.WREADY;
      @(negedge clk);
      aw_done |= hs_aw; w_done |= hs_w; cyc++;
      if (aw_done != w_done) begin
        chk("awready_half", 32'(bus.AWREADY), 32'(!aw_done));
        chk("wready_half",  32'(bus.WREADY),  32'(!w_done));
        chk("bvalid_early", 32'(bus.BVALID),  32'd0);
      end
    end
    bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
    if (!(aw_done && w_done)) begin
      chk("write_timeout", 32'd0, 32'd1);
      bus.BREADY = 1'b0;
      return;
    end
    mem[a[3:2]] = strobe_merge(mem[a[3:2]], d, s);
    chk("bvalid_rise", 32'(bus.BVALID), 32'd1);
    for (int i = 0; i < b_dly; i++) begin
      chk("bvalid_hold",  32'(bus.BVALID),  32'd1);
      chk("awready_resp", 32'(bus.AWREADY), 32'd0);
      chk("wready_resp",  32'(bus.WREADY),  32'd0);
      @(negedge clk);
    end
    bus.BREADY = 1'b1;
    @(negedge clk);
    bus.BREADY = 1'b0;
    chk("bvalid_fall",  32'(bus.BVALID),  32'd0);
    chk("awready_back", 32'(bus.AWREADY), 32'd1);
  endtask

  task automatic axi_read(input logic [3:0] a, input int r_dly);
    bit hs;
    int cyc;
    logic [31:0] exp;
    hs = 0; cyc = 0;
    exp = mem[a[3:2]];
    bus.RREADY = (r_dly == 0);
    bus.ARADDR = a;
    bus.ARVALID = 1'b1;
    while (!hs && cyc < 64) begin
      hs = bus.ARREADY;
      @(negedge clk);
      cyc++;
    end
    bus.ARVALID = 1'b0;
    if (!hs) begin
      chk("read_timeout", 32'd0, 32'd1);
      bus.RREADY = 1'b0;
      return;
    end
    chk("rvalid_rise", 32'(bus.RVALID), 32'd1);
    chk("rdata", bus.RDATA, exp);
    for (int i = 0; i < r_dly; i++) begin
      chk("rvalid_hold",  32'(bus.RVALID),  32'd1);
      chk("rdata_hold",   bus.RDATA, exp);
      chk("arready_data", 32'(bus.ARREADY), 32'd0);
      @(negedge clk);
    end
    bus.RREADY = 1'b1;
    @(negedge clk);
    bus.RREADY = 1'b0;
    chk("rvalid_fall",  32'(bus.RVALID),  32'd0);
    chk("rdata_keep",   bus.RDATA, exp);
    chk("arready_back", 32'(bus.ARREADY), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.AWADDR = '0; bus.AWVALID = 1'b0; bus.WDATA = '0; bus.WSTRB = '0; bus.WVALID = 1'b0;
    bus.BREADY = 1'b0; bus.ARADDR = '0; bus.ARVALID = 1'b0; bus.RREADY = 1'b0;
    for (int i = 0; i < 4; i++) mem[i] = '0;

    // Reset state
    #1;
    chk("rst_awready", 32'(bus.AWREADY), 32'd0);
    chk("rst_wready",  32'(bus.WREADY),  32'd0);
    chk("rst_arready", 32'(bus.ARREADY), 32'd0);
    chk("rst_bvalid",  32'(bus.BVALID),  32'd0);
    chk("rst_rvalid",  32'(bus.RVALID),  32'd0);
    chk("rst_rdata",   bus.RDATA, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_awready", 32'(bus.AWREADY), 32'd1);
    chk("idle_wready",  32'(bus.WREADY),  32'd1);
    chk("idle_arready", 32'(bus.ARREADY), 32'd1);

    // Simultaneous AW/W, then read back
    axi_write(4'h4, 32'hDEADBEEF, 4'hF, 0, 0, 0);
    axi_read(4'h4, 0);
    chk("lit_deadbeef", mem[1], 32'hDEADBEEF);

    // W leads AW by three cycles, then AW leads W
    axi_write(4'h8, 32'h11223344, 4'hF, 3, 0, 0);
    axi_read(4'h8, 0);
    axi_write(4'h0, 32'h55667788, 4'hF, 0, 2, 0);
    axi_read(4'h0, 0);

    // Partial and empty strobes
    axi_write(4'hC, 32'hAABBCCDD, 4'hF, 0, 0, 0);
    axi_write(4'hC, 32'h00000000, 4'h5, 0, 0, 0);
    chk("lit_strb5", mem[3], 32'hAA00CC00);
    axi_read(4'hC, 0);
    axi_write(4'hC, 32'h12345678, 4'h0, 0, 0, 0);
    axi_read(4'hC, 0);

    // Backpressure on both response channels
    axi_write(4'h4, 32'hCAFEF00D, 4'hF, 0, 0, 5);
    axi_read(4'h4, 4);

    // Read address handshake on the same edge as a write commit to the same register
    axi_write(4'h0, 32'h00000001, 4'hF, 0, 0, 0);
    bus.AWADDR = 4'h0; bus.WDATA = 32'h2; bus.WSTRB = 4'hF; bus.ARADDR = 4'h0;
    bus.AWVALID = 1'b1; bus.WVALID = 1'b1; bus.ARVALID = 1'b1;
    @(negedge clk);
    bus.AWVALID = 1'b0; bus.WVALID = 1'b0; bus.ARVALID = 1'b0;
    chk("coll_rdata",  bus.RDATA, 32'h1);
    chk("coll_bvalid", 32'(bus.BVALID), 32'd1);
    chk("coll_rvalid", 32'(bus.RVALID), 32'd1);
    mem[0] = 32'h2;
    bus.BREADY = 1'b1; bus.RREADY = 1'b1;
    @(negedge clk);
    bus.BREADY = 1'b0; bus.RREADY = 1'b0;
    chk("coll_bfall", 32'(bus.BVALID), 32'd0);
    chk("coll_rfall", 32'(bus.RVALID), 32'd0);
    axi_read(4'h0, 0);

    // Reset while a write response and read data are both outstanding
    bus.AWADDR = 4'h4; bus.WDATA = 32'h9999AAAA; bus.WSTRB = 4'hF; bus.ARADDR = 4'h8;
    bus.AWVALID = 1'b1; bus.WVALID = 1'b1; bus.ARVALID = 1'b1;
    @(negedge clk);
    bus.AWVALID = 1'b0; bus.WVALID = 1'b0; bus.ARVALID = 1'b0;
    chk("pre_rst_bvalid", 32'(bus.BVALID), 32'd1);
    chk("pre_rst_rvalid", 32'(bus.RVALID), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_bvalid",  32'(bus.BVALID),  32'd0);
    chk("mid_rst_rvalid",  32'(bus.RVALID),  32'd0);
    chk("mid_rst_awready", 32'(bus.AWREADY), 32'd0);
    chk("mid_rst_wready",  32'(bus.WREADY),  32'd0);
    chk("mid_rst_arready", 32'(bus.ARREADY), 32'd0);
    chk("mid_rst_rdata",   bus.RDATA, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) mem[i] = '0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) axi_read(4'(i * 4), 0);
    axi_write(4'h8, 32'h0BADC0DE, 4'hF, 1, 0, 1);
    axi_read(4'h8, 1);

    // Random traffic
    for (int k = 0; k < 150; k++) begin
      if ($urandom_range(1, 0) == 1)
        axi_write(4'($urandom), $urandom, 4'($urandom), int'($urandom_range(3, 0)),
                  int'($urandom_range(3, 0)), int'($urandom_range(3, 0)));
      else
        axi_read(4'($urandom), int'($urandom_range(3, 0)));
    end
    for (int i = 0; i < 4; i++) axi_read(4'(i * 4), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
